// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetches 16-bit big-endian instructions from byte-wide ROM and
//               buffers them in a 2-entry queue for the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_fetch_en,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_rd_en,
    input  logic [7:0]  i_mem_data,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [15:0] o_instruction,
    output logic [15:0] o_instr_pc,
    output logic [1:0]  o_queue_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ_HI = 3'd1;
    localparam logic [2:0] S_REQ_LO = 3'd2;
    localparam logic [2:0] S_PUSH   = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    localparam logic [1:0] c_QFULL = QDEPTH[1:0];

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [15:0] r_fetch_pc;
    logic [15:0] w_next_pc;
    logic [7:0]  r_hi_byte;
    logic [7:0]  r_lo_byte;
    logic        w_lat_hi;
    logic        w_lat_lo;

    // Entry 0 is always the head; entry 1 shifts down on pop.
    logic [15:0] r_head_instr;
    logic [15:0] r_head_pc;
    logic [15:0] r_tail_instr;
    logic [15:0] r_tail_pc;
    logic [1:0]  r_count;

    logic        w_pop;
    logic        w_space;
    logic        w_push;
    logic [15:0] w_push_word;
    logic        w_tail_slot;

    assign o_instr_valid = (r_count != 2'd0);
    assign o_queue_count = r_count;
    assign o_instruction = r_head_instr;
    assign o_instr_pc    = r_head_pc;

    // A redirect flushes the queue, so a handshake in that cycle is void.
    assign w_pop       = o_instr_valid & i_instr_ready & ~i_redirect;
    assign w_space     = (r_count < c_QFULL) | (o_instr_valid & i_instr_ready);
    assign w_tail_slot = (r_count == 2'd2) | ((r_count == 2'd1) & ~w_pop);

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_fetch_pc;
        w_push       = 1'b0;
        w_push_word  = {r_hi_byte, i_mem_data};
        w_lat_hi     = 1'b0;
        w_lat_lo     = 1'b0;
        o_mem_rd_en  = 1'b0;
        o_mem_addr   = r_fetch_pc;

        case (r_state)
            S_IDLE: begin
                if (i_fetch_en) w_next_state = S_REQ_HI;
            end
            S_REQ_HI: begin
                o_mem_rd_en  = 1'b1;
                w_next_state = S_REQ_LO;
            end
            S_REQ_LO: begin
                o_mem_rd_en  = 1'b1;
                o_mem_addr   = r_fetch_pc + 16'd1;
                w_lat_hi     = 1'b1;
                w_next_state = S_PUSH;
            end
            S_PUSH: begin
                if (w_space) begin
                    w_push       = 1'b1;
                    w_next_pc    = r_fetch_pc + 16'd2;
                    w_next_state = i_fetch_en ? S_REQ_HI : S_IDLE;
                end else begin
                    // Low byte is only on the bus this cycle; park it.
                    w_lat_lo     = 1'b1;
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                w_push_word = {r_hi_byte, r_lo_byte};
                if (w_space) begin
                    w_push       = 1'b1;
                    w_next_pc    = r_fetch_pc + 16'd2;
                    w_next_state = i_fetch_en ? S_REQ_HI : S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        if (i_redirect) begin
            w_push       = 1'b0;
            w_lat_lo     = 1'b0;
            w_next_pc    = i_redirect_pc;
            w_next_state = i_fetch_en ? S_REQ_HI : S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_hi_byte  <= 8'h00;
            r_lo_byte  <= 8'h00;
        end else begin
            r_state    <= w_next_state;
            r_fetch_pc <= w_next_pc;
            if (w_lat_hi) r_hi_byte <= i_mem_data;
            if (w_lat_lo) r_lo_byte <= i_mem_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_instr <= 16'h0000;
            r_head_pc    <= 16'h0000;
            r_tail_instr <= 16'h0000;
            r_tail_pc    <= 16'h0000;
            r_count      <= 2'd0;
        end else begin
            if (w_pop && (r_count == 2'd2)) begin
                r_head_instr <= r_tail_instr;
                r_head_pc    <= r_tail_pc;
            end
            if (w_push) begin
                if (w_tail_slot) begin
                    r_tail_instr <= w_push_word;
                    r_tail_pc    <= r_fetch_pc;
                end else begin
                    r_head_instr <= w_push_word;
                    r_head_pc    <= r_fetch_pc;
                end
            end
            if (i_redirect) begin
                r_count <= 2'd0;
            end else begin
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

endmodule
`default_nettype wire
